// File: rtl/wallace_pkg.sv
// Shared widths and row type for the 8x8 Wallace reduction pipeline.
package wallace_pkg;

    localparam int unsigned OP_W  = 8;
    localparam int unsigned ROW_W = 16;

    typedef logic [ROW_W-1:0] row_t;

endpackage

// File: rtl/csa_row.sv
// One 16-bit 3:2 compressor row: three rows in, sum row and left-shifted carry row out.
module csa_row
    import wallace_pkg::*;
(
    input  row_t x,
    input  row_t y,
    input  row_t z,
    output row_t sum,
    output row_t carry
);

    for (genvar i = 0; i < int'(ROW_W) - 1; i++) begin : g_fa
        full_adder u_fa (
            .a   (x[i]),
            .b   (y[i]),
            .cin (z[i]),
            .sum (sum[i]),
            .cout(carry[i+1])
        );
    end

    // Top bit keeps only its sum; its carry would land above bit 15 and is dropped.
    assign sum[ROW_W-1] = x[ROW_W-1] ^ y[ROW_W-1] ^ z[ROW_W-1];
    assign carry[0]     = 1'b0;

endmodule

// File: rtl/full_adder.sv
// Single-bit full adder cell used to build the carry-save compressor rows.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/wallace_reduction_pipe.sv
// Two-stage 8x8 Wallace partial-product reducer producing two rows for a final adder.
// Optional macro WALLACE_OP_COUNT_EN adds a 16-bit transfer counter output Op_Count.
module wallace_reduction_pipe
    import wallace_pkg::*;
(
    input  logic             CLK,
    input  logic             RST,
    input  logic             In_Valid,
    output logic             In_Ready,
    input  logic [OP_W-1:0]  A,
    input  logic [OP_W-1:0]  B,
    output logic             Out_Valid,
    input  logic             Out_Ready,
    output row_t             RowA,
    output row_t             RowB
`ifdef WALLACE_OP_COUNT_EN
    ,
    output logic [ROW_W-1:0] Op_Count
`endif
);

    row_t pp [OP_W];
    row_t l1_s0, l1_c0, l1_s1, l1_c1;
    row_t l2_s0, l2_c0, l2_s1, l2_c1;
    row_t l3_s, l3_c, l4_s, l4_c;
    row_t s1_r0, s1_r1, s1_r2, s1_r3;
    logic s1_valid;
    logic s1_advance;

    always_comb begin
        for (int i = 0; i < int'(OP_W); i++) begin
            pp[i] = row_t'(A & {OP_W{B[i]}}) << i;
        end
    end

    // Stage 1: 8 -> 6 -> 4 rows.
    csa_row u_l1a (.x(pp[0]), .y(pp[1]), .z(pp[2]), .sum(l1_s0), .carry(l1_c0));
    csa_row u_l1b (.x(pp[3]), .y(pp[4]), .z(pp[5]), .sum(l1_s1), .carry(l1_c1));
    csa_row u_l2a (.x(l1_s0), .y(l1_c0), .z(l1_s1), .sum(l2_s0), .carry(l2_c0));
    csa_row u_l2b (.x(l1_c1), .y(pp[6]), .z(pp[7]), .sum(l2_s1), .carry(l2_c1));

    // Stage 2: 4 -> 3 -> 2 rows.
    csa_row u_l3 (.x(s1_r0), .y(s1_r1), .z(s1_r2), .sum(l3_s), .carry(l3_c));
    csa_row u_l4 (.x(l3_s),  .y(l3_c),  .z(s1_r3), .sum(l4_s), .carry(l4_c));

    assign s1_advance = !Out_Valid || Out_Ready;
    assign In_Ready   = !s1_valid || s1_advance;

    always_ff @(posedge CLK) begin
        if (RST) begin
            s1_valid  <= 1'b0;
            s1_r0     <= '0;
            s1_r1     <= '0;
            s1_r2     <= '0;
            s1_r3     <= '0;
            Out_Valid <= 1'b0;
            RowA      <= '0;
            RowB      <= '0;
        end else begin
            if (In_Ready) begin
                s1_valid <= In_Valid;
                if (In_Valid) begin
                    s1_r0 <= l2_s0;
                    s1_r1 <= l2_c0;
                    s1_r2 <= l2_s1;
                    s1_r3 <= l2_c1;
                end
            end
            if (s1_advance) begin
                Out_Valid <= s1_valid;
                if (s1_valid) begin
                    RowA <= l4_s;
                    RowB <= l4_c;
                end
            end
        end
    end

`ifdef WALLACE_OP_COUNT_EN
    // Counts completed transfers, wrapping naturally at 16 bits.
    always_ff @(posedge CLK) begin
        if (RST) begin
            Op_Count <= '0;
        end else if (Out_Valid && Out_Ready) begin
            Op_Count <= Op_Count + ROW_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_wallace_reduction_pipe.sv
// Testbench for wallace_reduction_pipe with a queue-based output scoreboard.
module tb_wallace_reduction_pipe;

    logic        CLK = 1'b0;
    logic        RST;
    logic        In_Valid;
    logic        In_Ready;
    logic [7:0]  A;
    logic [7:0]  B;
    logic        Out_Valid;
    logic        Out_Ready;
    logic [15:0] RowA;
    logic [15:0] RowB;
`ifdef WALLACE_OP_COUNT_EN
    logic [15:0] Op_Count;
`endif

    wallace_reduction_pipe dut (
        .CLK      (CLK),
        .RST      (RST),
        .In_Valid (In_Valid),
        .In_Ready (In_Ready),
        .A        (A),
        .B        (B),
        .Out_Valid(Out_Valid),
        .Out_Ready(Out_Ready),
        .RowA     (RowA),
        .RowB     (RowB)
`ifdef WALLACE_OP_COUNT_EN
        ,
        .Op_Count (Op_Count)
`endif
    );

    always #5 CLK = ~CLK;

    int          checks = 0;
    int          errors = 0;
    int          xfers  = 0;
    bit          rand_ready = 1'b0;
    logic [15:0] exp_q [$];
    logic [16:0] mon_sum;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Monitor: full 17-bit row sum must equal the product exactly (no carry out of bit 15).
    always @(negedge CLK) begin
        if (!RST && Out_Valid === 1'b1 && Out_Ready === 1'b1) begin
            mon_sum = {1'b0, RowA} + {1'b0, RowB};
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output actual_sum=0x%0h required=none", mon_sum);
            end else begin
                check("row_sum", 32'(mon_sum), 32'(exp_q.pop_front()));
            end
            xfers++;
        end
    end

    always @(posedge CLK) begin
        if (rand_ready) begin
            #1 Out_Ready = 1'($urandom_range(0, 1));
        end
    end

    task automatic send(input logic [7:0] a, input logic [7:0] b);
        int n;
        A = a;
        B = b;
        In_Valid = 1'b1;
        n = 0;
        @(negedge CLK);
        while (!In_Ready && n < 200) begin
            @(negedge CLK);
            n++;
        end
        if (!In_Ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout actual=no_accept required=accept a=%0d b=%0d", a, b);
        end else begin
            exp_q.push_back(16'(a) * 16'(b));
        end
        @(posedge CLK);
        #1 In_Valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    initial begin
        int n;
        RST = 1'b1;
        In_Valid = 1'b0;
        A = '0;
        B = '0;
        Out_Ready = 1'b1;
        idle(2);
        RST = 1'b0;

        @(negedge CLK);
        check("rst_out_valid", 32'(Out_Valid), 32'd0);
        check("rst_in_ready", 32'(In_Ready), 32'd1);
        check("rst_row_a", 32'(RowA), 32'd0);
        check("rst_row_b", 32'(RowB), 32'd0);
        @(posedge CLK);
        #1;

        // Single op with latency check.
        send(8'hFF, 8'hFF);
        @(negedge CLK);
        check("latency_cycle1", 32'(Out_Valid), 32'd0);
        @(negedge CLK);
        check("latency_cycle2", 32'(Out_Valid), 32'd1);
        @(posedge CLK);
        #1;
        idle(2);

        // Back-to-back stream.
        send(8'd3, 8'd5);
        send(8'd0, 8'd200);
        send(8'd128, 8'd2);
        send(8'd17, 8'd15);
        idle(4);

        // Backpressure: fill both stages, hold, then release with a new input.
        Out_Ready = 1'b0;
        send(8'd10, 8'd10);
        send(8'd20, 8'd20);
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            check("full_in_ready", 32'(In_Ready), 32'd0);
            check("full_out_valid", 32'(Out_Valid), 32'd1);
            check("full_hold_sum", 32'(16'(RowA + RowB)), 32'd100);
        end
        @(posedge CLK);
        #1;
        A = 8'd3;
        B = 8'd3;
        In_Valid = 1'b1;
        Out_Ready = 1'b1;
        @(negedge CLK);
        check("release_accept", 32'(In_Ready), 32'd1);
        exp_q.push_back(16'd9);
        @(posedge CLK);
        #1 In_Valid = 1'b0;
        idle(4);

        // Reset mid-flight discards the in-flight product.
        send(8'd7, 8'd9);
        RST = 1'b1;
        exp_q.delete();
        xfers = 0;
        @(posedge CLK);
        #1 RST = 1'b0;
        @(negedge CLK);
        check("post_rst_in_ready", 32'(In_Ready), 32'd1);
        for (int i = 0; i < 4; i++) begin
            check("post_rst_out_valid", 32'(Out_Valid), 32'd0);
            @(negedge CLK);
        end
        @(posedge CLK);
        #1;

        // Random traffic with random backpressure.
        rand_ready = 1'b1;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                idle(1);
            end else begin
                send(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
            end
        end
        rand_ready = 1'b0;
        @(posedge CLK);
        #2 Out_Ready = 1'b1;

        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(posedge CLK);
            n++;
        end
        @(negedge CLK);
        check("drain_empty", 32'(exp_q.size()), 32'd0);
        check("final_out_valid", 32'(Out_Valid), 32'd0);
`ifdef WALLACE_OP_COUNT_EN
        check("op_count", 32'(Op_Count), 32'(xfers[15:0]));
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
